// File: rtl/local_flit_assembler.sv
// Purpose : rebuild PACKET_W-bit spike packets from serial FLIT_W-bit router flits and queue them.
// Latency : packet_valid rises the cycle after the last flit is accepted into an empty queue.
// Backpress: full (queue holds DEPTH packets) stops flit acceptance; packet_ready pops the head.
//
// Ports:
//   clk, rst_n                  core clock, asynchronous active-low reset
//   flit_in, flit_valid         flit from the router local output
//   full                        back to the router; flit refused while high
//   packet_out, packet_valid    queue head and non-empty flag
//   packet_ready                consumer takes the head when high with packet_valid
//   frag_err                    one-cycle pulse when a stalled partial packet is dropped
//   pkt_count                   complete packets received, wrapping 16-bit counter

// Generic packet queue used by the assembler.
// Purpose : DEPTH-entry FIFO, head visible combinationally from storage.
// Latency : a push is visible at the head the following cycle; no push/pop bypass.
module flit_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module local_flit_assembler #(
    parameter int PACKET_W = 32,
    parameter int FLIT_W   = 4,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FLIT_W-1:0]   flit_in,
    input  logic                flit_valid,
    output logic                full,
    output logic [PACKET_W-1:0] packet_out,
    output logic                packet_valid,
    input  logic                packet_ready,
    output logic                frag_err,
    output logic [15:0]         pkt_count
);
    // A packet is at least two flits, so the shift register slice below is never empty.
    localparam int NF = PACKET_W / FLIT_W;
    localparam int NW = $clog2(NF);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ASSEMBLE} state_t;

    state_t              state_q, state_d;
    logic [NW-1:0]       nib_q, nib_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic [PACKET_W-1:0] asm_q, asm_d;
    logic                frag_q, frag_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                accept, push, pop;
    logic [CW-1:0]       fifo_cnt;
    logic [PACKET_W-1:0] push_dat;

    // full comes straight from the count register: a pop this cycle does not free a slot until next cycle.
    assign full         = (fifo_cnt == CW'(DEPTH));
    assign packet_valid = (fifo_cnt != '0);
    assign accept       = flit_valid && !full;
    assign pop          = packet_valid && packet_ready;
    // First flit is the most significant; the last flit is appended on the way into the queue.
    assign push_dat     = {asm_q[PACKET_W-FLIT_W-1:0], flit_in};

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        idle_d  = idle_q;
        asm_d   = asm_q;
        frag_d  = 1'b0;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (accept) begin
            asm_d = push_dat;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ASSEMBLE;
                    nib_d   = NW'(1);
                    idle_d  = '0;
                end
            end
            ASSEMBLE: begin
                if (accept) begin
                    // A flit arriving in the timeout cycle wins over the discard.
                    idle_d = '0;
                    if (nib_q == NW'(NF - 1)) begin
                        push    = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = IDLE;
                        nib_d   = '0;
                    end else begin
                        nib_d = nib_q + NW'(1);
                    end
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    frag_d  = 1'b1;
                    state_d = IDLE;
                    nib_d   = '0;
                    idle_d  = '0;
                    asm_d   = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nib_q   <= '0;
            idle_q  <= '0;
            asm_q   <= '0;
            frag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            idle_q  <= idle_d;
            asm_q   <= asm_d;
            frag_q  <= frag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frag_err  = frag_q;
    assign pkt_count = cnt_q;

    flit_fifo #(.W(PACKET_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (packet_out),
        .cnt      (fifo_cnt)
    );

    // Acceptance is gated by full, so a push into a full queue means the gating is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: tb/tb_local_flit_assembler.sv
module tb_local_flit_assembler;
    localparam int PACKET_W = 32;
    localparam int FLIT_W   = 4;
    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 64;
    localparam int NF       = PACKET_W / FLIT_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [FLIT_W-1:0]   flit_in = '0;
    logic                flit_valid = 1'b0;
    logic                full;
    logic [PACKET_W-1:0] packet_out;
    logic                packet_valid;
    logic                packet_ready = 1'b0;
    logic                frag_err;
    logic [15:0]         pkt_count;

    local_flit_assembler #(
        .PACKET_W(PACKET_W), .FLIT_W(FLIT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
        .full(full), .packet_out(packet_out), .packet_valid(packet_valid),
        .packet_ready(packet_ready), .frag_err(frag_err), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of whole packets, list of flits collected so far.
    logic [PACKET_W-1:0] m_q[$];
    logic [FLIT_W-1:0]   m_nibs[$];
    int                  m_idle;
    logic                m_frag;
    logic [15:0]         m_cnt;
    bit                  m_fresh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_nibs.delete();
        m_idle  = 0;
        m_frag  = 1'b0;
        m_cnt   = '0;
        m_fresh = 1'b1;
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model, wait for the rising edge.
    task automatic cycle(input bit v, input logic [FLIT_W-1:0] f, input bit rdy, output bit acc);
        logic [PACKET_W-1:0] p;
        @(negedge clk);
        chk("full", full, m_q.size() == DEPTH);
        chk("packet_valid", packet_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("packet_out", packet_out, m_q[0]);
        else if (m_fresh) chk("packet_out_idle", packet_out, '0);
        chk("frag_err", frag_err, m_frag);
        chk("pkt_count", pkt_count, m_cnt);
        flit_valid   = v;
        flit_in      = f;
        packet_ready = rdy;
        acc    = v && (m_q.size() != DEPTH);
        m_frag = 1'b0;
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (acc) begin
            m_nibs.push_back(f);
            m_idle = 0;
            if (m_nibs.size() == NF) begin
                p = '0;
                foreach (m_nibs[i]) p = (p << FLIT_W) | PACKET_W'(m_nibs[i]);
                m_q.push_back(p);
                m_cnt   = m_cnt + 16'd1;
                m_fresh = 1'b0;
                m_nibs.delete();
            end
        end else if (m_nibs.size() != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_nibs.delete();
                m_idle = 0;
                m_frag = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit a;
        repeat (n) cycle(1'b0, '0, rdy, a);
    endtask

    // Hold a flit on the bus until it is taken, like the router does.
    task automatic send_flit(input logic [FLIT_W-1:0] f, input bit rdy);
        bit a;
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, f, rdy, a);
            tries++;
        end while (!a && tries < 200);
        if (!a) chk("flit_accept_budget", 32'(tries), 32'd0);
    endtask

    task automatic send_pkt(input logic [PACKET_W-1:0] p, input int gap, input bit rdy);
        for (int i = 0; i < NF; i++) begin
            send_flit(p[PACKET_W-1-FLIT_W*i -: FLIT_W], rdy);
            if (i < NF - 1) idle(gap, rdy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        flit_valid   = 1'b0;
        packet_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_full", full, 0);
        chk("rst_packet_valid", packet_valid, 0);
        chk("rst_packet_out", packet_out, 0);
        chk("rst_frag_err", frag_err, 0);
        chk("rst_pkt_count", pkt_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit a;
        logic [PACKET_W-1:0] rp;
        model_reset();
        do_reset();

        // Back-to-back 1..8 with the consumer ready.
        for (int i = 1; i <= NF; i++) send_flit(FLIT_W'(i), 1'b1);
        #1;
        chk("t1_packet_out", packet_out, 32'h12345678);
        chk("t1_packet_valid", packet_valid, 1);
        chk("t1_pkt_count", pkt_count, 1);
        idle(1, 1'b1);
        #1 chk("t1_valid_one_cycle", packet_valid, 0);

        // Gapped flits well inside the timeout.
        send_pkt(32'hDEADBEEF, 3, 1'b0);
        #1 chk("t2_packet_out", packet_out, 32'hDEADBEEF);
        idle(2, 1'b1);

        // Stall of exactly TIMEOUT-1 idle cycles survives.
        for (int i = 0; i < 3; i++) send_flit(FLIT_W'(9 + i), 1'b1);
        idle(TIMEOUT - 1, 1'b1);
        #1 chk("t3_no_frag_boundary", frag_err, 0);
        for (int i = 3; i < NF; i++) send_flit(FLIT_W'(9 + i), 1'b1);
        #1 chk("t3_survivor", packet_out, 32'h9ABCDEF0);
        idle(2, 1'b1);

        // Stall of TIMEOUT idle cycles is discarded, next packet is clean.
        for (int i = 0; i < 3; i++) send_flit(FLIT_W'(3), 1'b1);
        idle(TIMEOUT, 1'b1);
        #1 chk("t4_frag_pulse", frag_err, 1);
        idle(1, 1'b1);
        #1 chk("t4_frag_single", frag_err, 0);
        send_pkt(32'hABCDEF01, 0, 1'b0);
        #1 chk("t4_clean_packet", packet_out, 32'hABCDEF01);
        idle(2, 1'b1);

        // Fill the queue, hold a flit while full, free one slot for one cycle.
        for (int k = 0; k < DEPTH; k++) send_pkt($urandom, 0, 1'b0);
        #1 chk("t5_full", full, 1);
        cycle(1'b1, 4'h7, 1'b0, a);
        cycle(1'b1, 4'h7, 1'b0, a);
        #1 chk("t5_still_full", full, 1);
        cycle(1'b1, 4'h7, 1'b1, a);
        #1 chk("t5_full_drops", full, 0);
        send_flit(4'h7, 1'b0);
        for (int i = 1; i < NF; i++) send_flit(FLIT_W'(i), 1'b1);
        idle(DEPTH + 2, 1'b1);

        // Push and pop together at DEPTH-1 keep the count.
        for (int k = 0; k < DEPTH - 1; k++) send_pkt($urandom, 0, 1'b0);
        rp = $urandom;
        for (int i = 0; i < NF - 1; i++) send_flit(rp[PACKET_W-1-FLIT_W*i -: FLIT_W], 1'b0);
        cycle(1'b1, rp[FLIT_W-1:0], 1'b1, a);
        #1 chk("t6_not_full", full, 0);
        send_pkt($urandom, 0, 1'b0);
        #1 chk("t6_full_after_one_more", full, 1);
        idle(DEPTH + 2, 1'b1);

        // Reset mid-packet with two packets queued.
        send_pkt($urandom, 0, 1'b0);
        send_pkt($urandom, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_flit(4'hF, 1'b0);
        do_reset();
        send_pkt(32'h0F1E2D3C, 0, 1'b0);
        #1 chk("t7_after_reset", packet_out, 32'h0F1E2D3C);
        chk("t7_count_after_reset", pkt_count, 1);
        idle(2, 1'b1);

        // Random traffic with occasional long stalls.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 24) == 0) idle($urandom_range(TIMEOUT - 6, TIMEOUT + 6), 1'($urandom_range(0, 1)));
            else cycle($urandom_range(0, 9) < 7, FLIT_W'($urandom), 1'($urandom_range(0, 1)), a);
        end
        idle(DEPTH + 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
